// File: rtl/t_ff_sync_counter_pkg.sv
// Shared constants for the T-cell counter family: default sizing and the
// count-direction encoding reused by later counter blocks.
package t_ff_sync_counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;
    localparam int COUNTER_MOD_DEFAULT   = 16;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop cell with complementary outputs; toggles on a rising
// clock edge when t is high, clears asynchronously on rst.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

    assign qb = ~q;

endmodule

// File: rtl/t_ff_sync_counter.sv
// Synchronous modulo-MOD up/down counter with parallel load, built from one
// T cell per bit; this level only decides which cells toggle each edge.
module t_ff_sync_counter
    import t_ff_sync_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT,
    parameter int MOD   = COUNTER_MOD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             load_err
);

    generate
        if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
            $error("t_ff_sync_counter: MOD must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t_vec;
    logic             load_err_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_VAL);
    assign at_zero = (q == '0);

    // Wraps compare against MOD-1 and 0 so non-power-of-two moduli never
    // step into unused codes.
    always_comb begin
        next_q        = q;
        load_err_next = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                next_q = load_val;
            end else begin
                next_q        = '0;
                load_err_next = 1'b1;
            end
        end else if (en) begin
            if (up == DIR_UP)
                next_q = at_max ? '0 : q + 1'b1;
            else
                next_q = at_zero ? MAX_VAL : q - 1'b1;
        end
    end

    assign t_vec = q ^ next_q;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            t_ff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (t_vec[i]),
                .q   (q[i]),
                .qb  (qb[i])
            );
        end
    endgenerate

    assign tc = en & ~load & ~rst &
                (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            load_err <= 1'b0;
        else
            load_err <= load_err_next;
    end

endmodule

// File: tb/tb_t_ff_sync_counter.sv
// Directed bench for t_ff_sync_counter: a MOD=10 instance for wrap, load,
// range-error and async-reset cases, plus a default MOD=16 instance.
module tb_t_ff_sync_counter;

    logic       clk;
    logic       rst;

    logic       en, up, load;
    logic [3:0] load_val;
    logic [3:0] q, qb;
    logic       tc, load_err;

    logic       en16, up16, load16;
    logic [3:0] load_val16;
    logic [3:0] q16, qb16;
    logic       tc16, load_err16;

    int errors = 0;
    int checks = 0;

    t_ff_sync_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .qb       (qb),
        .tc       (tc),
        .load_err (load_err)
    );

    t_ff_sync_counter dut16 (
        .clk      (clk),
        .rst      (rst),
        .en       (en16),
        .up       (up16),
        .load     (load16),
        .load_val (load_val16),
        .q        (q16),
        .qb       (qb16),
        .tc       (tc16),
        .load_err (load_err16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit sel16, input logic l, input logic [3:0] lv,
                                 input logic e, input logic u);
        if (sel16) begin
            load16 = l; load_val16 = lv; en16 = e; up16 = u;
        end else begin
            load = l; load_val = lv; en = e; up = u;
        end
    endtask

    initial begin
        int exp_q;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_q", 32'(q), 32'd0);
        checkOutput("reset_qb", 32'(qb), 32'hF);
        checkOutput("reset_tc", 32'(tc), 32'd0);
        checkOutput("reset_load_err", 32'(load_err), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        // Count up through the MOD=10 wrap: 0..9,0,1
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_q = i % 10;
            checkOutput("up_q", 32'(q), 32'(exp_q));
            checkOutput("up_qb", 32'(qb), 32'(~exp_q & 4'hF));
            checkOutput("up_tc", 32'(tc), (exp_q == 9) ? 32'd1 : 32'd0);
        end

        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        checkOutput("down_q0", 32'(q), 32'd0);
        checkOutput("down_tc0", 32'(tc), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("down_q", 32'(q), 32'(10 - k));
            checkOutput("down_tc", 32'(tc), 32'd0);
        end

        // Load beats en even when q sits at the terminal value
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
        #1;
        checkOutput("ld_pre_q", 32'(q), 32'd9);
        checkOutput("ld_tc", 32'(tc), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        #1;
        checkOutput("ld_q", 32'(q), 32'd7);
        checkOutput("ld_load_err", 32'(load_err), 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
        #1;
        checkOutput("ld_next_q", 32'(q), 32'd8);

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checkOutput("bad_ld_q", 32'(q), 32'd0);
        checkOutput("bad_ld_err", 32'(load_err), 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        #1;
        checkOutput("bad_ld_err_clr", 32'(load_err), 32'd0);
        checkOutput("bad_ld_q_hold", 32'(q), 32'd0);

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        #1;
        checkOutput("pre_rst_q", 32'(q), 32'd5);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_q", 32'(q), 32'd0);
        checkOutput("mid_rst_qb", 32'(qb), 32'hF);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_rst_q", 32'(q), 32'd1);

        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'd14, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        #1;
        checkOutput("m16_q14", 32'(q16), 32'd14);
        checkOutput("m16_tc14", 32'(tc16), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("m16_q15", 32'(q16), 32'd15);
        checkOutput("m16_tc15", 32'(tc16), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("m16_wrap_q", 32'(q16), 32'd0);
        checkOutput("m16_wrap_qb", 32'(qb16), 32'hF);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, j[0]);
            #1;
            checkOutput("m16_hold_q", 32'(q16), 32'd0);
            checkOutput("m16_hold_tc", 32'(tc16), 32'd0);
        end
        checkOutput("m16_load_err", 32'(load_err16), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/t_ff_sync_counter.md
Name: t_ff_sync_counter

Overview:
- Synchronous modulo-MOD up/down counter built from per-bit T flip-flop cells.
- Sits directly downstream of the T flip-flop stage.
  - Each bit is a T cell.
  - Each cell's toggle input is generated here from the current count and the controls.
- Provides parallel load, a combinational terminal-count output for cascading, and complementary outputs q/qb matching the T-cell convention.

Parameters:
- WIDTH, 4, number of count bits / T cells.
- MOD, 16, count modulus; range is 0..MOD-1. Legal values are 2..2^WIDTH; any other value is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable, sampled on the rising edge of clk
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load request, higher priority than en
- load_val  input  WIDTH  value to load
- q  output  WIDTH  current count (registered)
- qb  output  WIDTH  bitwise complement of q, always
- tc  output  1  terminal count, combinational
- load_err  output  1  one-cycle registered pulse on an out-of-range load

Behaviour:
- Reset:
  - rst high clears all state immediately, without waiting for a clock edge.
  - Reset values: q=0, qb=all ones, load_err=0.
  - tc follows its combinational equation; it is therefore 0 during reset, because en is ignored while rst is high.
  - rst takes effect at any time, including mid-count or on the same edge as load. The first count happens on the first rising edge after rst falls.
- Next-value selection, evaluated at each rising edge with priority top to bottom:
  - rst high: hold reset.
  - load=1 and load_val<MOD: next=load_val, load_err<=0.
  - load=1 and load_val>=MOD: next=0, load_err<=1 for exactly one cycle.
  - en=1, up=1: next = (q==MOD-1) ? 0 : q+1.
  - en=1, up=0: next = (q==0) ? MOD-1 : q-1.
  - Otherwise: next=q, hold.
- Toggle generation:
  - Toggle vector t_vec = q XOR next.
  - Bit i toggles iff t_vec[i]=1.
  - When MOD=2^WIDTH, the up-count case must reduce to the classic rule t[i] = en & AND(q[i-1:0]).
- Latency: q reflects a load or count one clock after the edge on which the request is sampled. No combinational path exists from any input to q or qb.
- load_err deasserts on the next edge unless another out-of-range load is present on that edge.
- tc = en & ~load & ~rst & ((up & q==MOD-1) | (~up & q==0)).
  - tc is high during the cycle in which the wrap edge will occur, so a downstream counter stage can use it as its en.
- up changing between edges: only the value sampled at the edge matters. tc follows up combinationally.
- Simultaneous load and en: load wins. tc is 0 in that cycle.
- Arithmetic is WIDTH bits, unsigned. The wrap comparisons use MOD-1 and 0, never overflow, so non-power-of-two MOD values never visit illegal states.

Decomposition:
- Shared package/include file holds:
  - default constants (COUNTER_WIDTH_DEFAULT=4, COUNTER_MOD_DEFAULT=16);
  - a direction encoding (DIR_DOWN=0, DIR_UP=1), reused by later counter blocks.
- One sub-module, t_ff_cell:
  - ports clk, rst, t, q, qb;
  - async active-high reset to q=0;
  - q toggles on a rising edge when t=1.
- t_ff_sync_counter instantiates WIDTH t_ff_cell instances via generate. It contains only the next-value, toggle, tc and load_err logic.

Test Plan:
- WIDTH=4, MOD=10; reset, then en=1, up=1 for 12 cycles -> q=0,1,…,9,0,1; qb=~q every cycle; tc=1 only while q=9.
- WIDTH=4, MOD=10; q=0, en=1, up=0 for 3 cycles -> q=9,8,7; tc=1 during the q=0 cycle only.
- WIDTH=4, MOD=10; load=1, load_val=7, en=1 on the same edge -> q=7 (load wins), tc=0 that cycle; next edge with en=1, up=1 -> q=8.
- WIDTH=4, MOD=10; load=1, load_val=12 -> q=0, load_err=1 for one cycle, then 0.
- Defaults (MOD=16); count up from 14 -> 15 then 0 with tc=1 at 15. Separately: en=0 while toggling up for 5 cycles -> q holds, tc=0.
- Assert rst for 3 ns midway between clock edges while q=5 -> q=0, qb=4'b1111 immediately; after rst falls, the first en edge gives q=1.
